// File: rtl/matmul_seq_ctrl_if.sv
// Bus between the matmul sequencer and its neighbours: UART rx/tx, operand
// buffers, multiplier core and result buffer. master = sequencer side.
interface matmul_seq_ctrl_if #(
  parameter int MAX_DIM    = 8,
  parameter int ELEM_BYTES = 1,
  parameter int RES_BYTES  = 2
);
  localparam int DIM_W  = $clog2(MAX_DIM + 1);
  localparam int ADDR_W = $clog2(MAX_DIM * MAX_DIM);

  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic                    tx_busy;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    mult_start;
  logic                    mult_done;
  logic [DIM_W-1:0]        dim_m;
  logic [DIM_W-1:0]        dim_k;
  logic [DIM_W-1:0]        dim_n;
  logic                    wr_en_a;
  logic                    wr_en_b;
  logic [ADDR_W-1:0]       wr_addr;
  logic [8*ELEM_BYTES-1:0] wr_data;
  logic [ADDR_W-1:0]       res_rd_addr;
  logic [8*RES_BYTES-1:0]  res_rd_data;
  logic [2:0]              state;
  logic [1:0]              err_code;

  modport master (
    input  rx_valid, rx_data, tx_busy, mult_done, res_rd_data,
    output tx_start, tx_data, mult_start, dim_m, dim_k, dim_n,
           wr_en_a, wr_en_b, wr_addr, wr_data, res_rd_addr, state, err_code
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, mult_done, res_rd_data,
    input  tx_start, tx_data, mult_start, dim_m, dim_k, dim_n,
           wr_en_a, wr_en_b, wr_addr, wr_data, res_rd_addr, state, err_code
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the UART-attached matrix multiplier: header parse, operand
// load (A is MxK, B is KxN), multiply kick-off and byte-wise result stream-out.
module matmul_seq_ctrl #(
  parameter int MAX_DIM    = 8,
  parameter int ELEM_BYTES = 1,
  parameter int RES_BYTES  = 2,
  parameter int TIMEOUT    = 1_000_000
) (
  input logic               clk,
  input logic               rst_n,
  matmul_seq_ctrl_if.master bus
);
  localparam int DIM_W  = $clog2(MAX_DIM + 1);
  localparam int ADDR_W = $clog2(MAX_DIM * MAX_DIM);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int ELEM_W = 8 * ELEM_BYTES;
  localparam int RES_W  = 8 * RES_BYTES;

  localparam logic [3:0]      ELEM_LAST = 4'(ELEM_BYTES - 1);
  localparam logic [3:0]      RES_LAST  = 4'(RES_BYTES - 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [7:0]      ERR_BYTE  = 8'hEE;
  localparam logic [7:0]      MAX_DIM_B = 8'(MAX_DIM);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_B  = 3'd3,
    COMPUTE = 3'd4,
    FETCH   = 3'd5,
    SEND    = 3'd6,
    ERR     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DIMS    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  state_e              state_q;
  err_e                err_q;
  logic [DIM_W-1:0]    dim_m_q, dim_k_q, dim_n_q;
  logic [1:0]          hdr_idx_q;
  logic                hdr_bad_q;
  logic [CNT_W-1:0]    elem_cnt_q;
  logic [CNT_W-1:0]    res_cnt_q;
  logic [3:0]          byte_idx_q;
  logic [ELEM_W-1:0]   elem_buf_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                wr_en_a_q, wr_en_b_q, mult_start_q, tx_start_q, fetch_wait_q;
  logic [ADDR_W-1:0]   wr_addr_q, res_rd_addr_q;
  logic [ELEM_W-1:0]   wr_data_q;
  logic [RES_W-1:0]    res_q;
  logic [7:0]          tx_data_q;

  logic [CNT_W-1:0]    prod_mk, prod_kn, prod_mn, elem_cnt_inc, res_cnt_inc, load_total;
  logic [ELEM_W-1:0]   elem_d;
  logic [RES_W-1:0]    send_word;
  logic [3:0]          send_idx;
  logic [7:0]          send_byte;
  logic                dim_bad, elem_done, load_st, to_expire;
  logic                can_tx, send_act, send_last;

  // NOTE: every signal gets an unconditional value here, so no latches are inferred.
  always_comb begin
    prod_mk      = CNT_W'(dim_m_q) * CNT_W'(dim_k_q);
    prod_kn      = CNT_W'(dim_k_q) * CNT_W'(dim_n_q);
    prod_mn      = CNT_W'(dim_m_q) * CNT_W'(dim_n_q);
    load_total   = (state_q == LOAD_A) ? prod_mk : prod_kn;
    elem_cnt_inc = elem_cnt_q + CNT_W'(1);
    res_cnt_inc  = res_cnt_q + CNT_W'(1);
    elem_d       = elem_buf_q | (ELEM_W'(bus.rx_data) << {byte_idx_q, 3'b000});
    elem_done    = (byte_idx_q == ELEM_LAST);
    dim_bad      = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_DIM_B);
    load_st      = (state_q == HDR) || (state_q == LOAD_A) || (state_q == LOAD_B);
    to_expire    = load_st && !bus.rx_valid && (to_cnt_q == TO_LAST);
    // The read-data cycle of FETCH already issues byte 0, straight from the buffer.
    send_word    = (state_q == FETCH) ? bus.res_rd_data : res_q;
    send_idx     = (state_q == FETCH) ? 4'd0 : byte_idx_q;
    send_byte    = 8'(send_word >> {send_idx, 3'b000});
    send_last    = (send_idx == RES_LAST);
    can_tx       = !bus.tx_busy && !tx_start_q;
    send_act     = can_tx && (((state_q == FETCH) && fetch_wait_q) || (state_q == SEND));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      err_q         <= ERR_NONE;
      dim_m_q       <= '0;
      dim_k_q       <= '0;
      dim_n_q       <= '0;
      hdr_idx_q     <= '0;
      hdr_bad_q     <= 1'b0;
      elem_cnt_q    <= '0;
      res_cnt_q     <= '0;
      byte_idx_q    <= '0;
      elem_buf_q    <= '0;
      to_cnt_q      <= '0;
      wr_en_a_q     <= 1'b0;
      wr_en_b_q     <= 1'b0;
      mult_start_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      fetch_wait_q  <= 1'b0;
      wr_addr_q     <= '0;
      res_rd_addr_q <= '0;
      wr_data_q     <= '0;
      res_q         <= '0;
      tx_data_q     <= '0;
    end else begin
      // NOTE: strobes default low each cycle; later assignments in this block take priority.
      wr_en_a_q    <= 1'b0;
      wr_en_b_q    <= 1'b0;
      mult_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      to_cnt_q     <= (load_st && !bus.rx_valid) ? to_cnt_q + TO_W'(1) : '0;

      case (state_q)
        IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            state_q   <= HDR;
            err_q     <= ERR_NONE;
            hdr_idx_q <= '0;
            hdr_bad_q <= 1'b0;
          end
        end
        HDR: begin
          if (bus.rx_valid) begin
            hdr_idx_q <= hdr_idx_q + 2'd1;
            hdr_bad_q <= hdr_bad_q | dim_bad;
            case (hdr_idx_q)
              2'd0:    dim_m_q <= DIM_W'(bus.rx_data);
              2'd1:    dim_k_q <= DIM_W'(bus.rx_data);
              default: begin
                dim_n_q <= DIM_W'(bus.rx_data);
                if (hdr_bad_q || dim_bad) begin
                  state_q <= ERR;
                  err_q   <= ERR_DIMS;
                end else begin
                  state_q <= LOAD_A;
                end
              end
            endcase
          end
        end
        LOAD_A, LOAD_B: begin
          if (bus.rx_valid) begin
            if (elem_done) begin
              wr_data_q  <= elem_d;
              wr_addr_q  <= ADDR_W'(elem_cnt_q);
              wr_en_a_q  <= (state_q == LOAD_A);
              wr_en_b_q  <= (state_q == LOAD_B);
              elem_buf_q <= '0;
              byte_idx_q <= '0;
              if (elem_cnt_inc == load_total) begin
                elem_cnt_q <= '0;
                if (state_q == LOAD_A) begin
                  state_q <= LOAD_B;
                end else begin
                  state_q      <= COMPUTE;
                  mult_start_q <= 1'b1;
                end
              end else begin
                elem_cnt_q <= elem_cnt_inc;
              end
            end else begin
              elem_buf_q <= elem_d;
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end
        COMPUTE: begin
          // A done seen on the start cycle is stale from the previous job.
          if (bus.mult_done && !mult_start_q) begin
            state_q       <= FETCH;
            res_cnt_q     <= '0;
            res_rd_addr_q <= '0;
            fetch_wait_q  <= 1'b0;
          end
        end
        FETCH: begin
          if (!fetch_wait_q) begin
            fetch_wait_q <= 1'b1;
          end else begin
            fetch_wait_q <= 1'b0;
            res_q        <= bus.res_rd_data;
            byte_idx_q   <= '0;
            state_q      <= SEND;
          end
        end
        SEND: ;
        ERR: begin
          if (can_tx) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ERR_BYTE;
            state_q    <= IDLE;
          end
        end
      endcase

      if (send_act) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= send_byte;
        if (send_last) begin
          byte_idx_q <= '0;
          if (res_cnt_inc == prod_mn) begin
            res_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            res_cnt_q     <= res_cnt_inc;
            res_rd_addr_q <= ADDR_W'(res_cnt_inc);
            state_q       <= FETCH;
          end
        end else begin
          byte_idx_q <= send_idx + 4'd1;
          state_q    <= SEND;
        end
      end

      if (to_expire) begin
        state_q    <= ERR;
        err_q      <= ERR_TIMEOUT;
        elem_buf_q <= '0;
        byte_idx_q <= '0;
        elem_cnt_q <= '0;
        to_cnt_q   <= '0;
      end
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.mult_start  = mult_start_q;
  assign bus.dim_m       = dim_m_q;
  assign bus.dim_k       = dim_k_q;
  assign bus.dim_n       = dim_n_q;
  assign bus.wr_en_a     = wr_en_a_q;
  assign bus.wr_en_b     = wr_en_b_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.res_rd_addr = res_rd_addr_q;
  assign bus.state       = state_q;
  assign bus.err_code    = err_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: one instance with 1-byte elements and a
// short timeout, a second with 2-byte elements for element assembly.
module tb_matmul_seq_ctrl;
  localparam int TO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.MAX_DIM(8), .ELEM_BYTES(1), .RES_BYTES(2)) if0 ();
  matmul_seq_ctrl_if #(.MAX_DIM(8), .ELEM_BYTES(2), .RES_BYTES(2)) if1 ();

  matmul_seq_ctrl #(.MAX_DIM(8), .ELEM_BYTES(1), .RES_BYTES(2), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  matmul_seq_ctrl #(.MAX_DIM(8), .ELEM_BYTES(2), .RES_BYTES(2), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Result buffer, UART tx and multiplier models for dut0
  logic [15:0] res_mem [64];
  int busy_len = 5;
  int busy_cnt = 0;
  int mult_cnt = 0;

  assign if0.tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (if0.tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if0.res_rd_data <= res_mem[if0.res_rd_addr];
    if0.mult_done   <= (mult_cnt == 1);
    if (if0.mult_start) mult_cnt <= 3;
    else if (mult_cnt != 0) mult_cnt <= mult_cnt - 1;
  end

  assign if1.tx_busy     = 1'b0;
  assign if1.mult_done   = 1'b0;
  assign if1.res_rd_data = '0;

  // Event logs, sampled mid-cycle
  logic [7:0]  tx_q [$];
  logic [5:0]  wa_addr [$];
  logic [7:0]  wa_data [$];
  logic [5:0]  wb_addr [$];
  logic [7:0]  wb_data [$];
  logic [15:0] w1a_data [$];
  logic [15:0] w1b_data [$];
  int cyc = 0, last_tx_cyc = -100, first_tx_cyc = -1, done_cyc = -1000;
  int last_rx_cyc = 0, ms_gap = -1, ms_cnt = 0, ms1_cnt = 0;
  int busy_viol = 0, gap_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (if0.tx_start) begin
      tx_q.push_back(if0.tx_data);
      if (if0.tx_busy) busy_viol++;
      if (cyc - last_tx_cyc < 2) gap_viol++;
      last_tx_cyc = cyc;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
    end
    if (if0.wr_en_a) begin wa_addr.push_back(if0.wr_addr); wa_data.push_back(if0.wr_data); end
    if (if0.wr_en_b) begin wb_addr.push_back(if0.wr_addr); wb_data.push_back(if0.wr_data); end
    if (if0.mult_start) begin ms_cnt++; ms_gap = cyc - last_rx_cyc; end
    if (if0.mult_done) done_cyc = cyc;
    if (if0.rx_valid) last_rx_cyc = cyc;
    if (if1.wr_en_a) w1a_data.push_back(if1.wr_data);
    if (if1.wr_en_b) w1b_data.push_back(if1.wr_data);
    if (if1.mult_start) ms1_cnt++;
  end

  task automatic clear_logs();
    tx_q.delete(); wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    ms_cnt = 0; first_tx_cyc = -1; busy_viol = 0; gap_viol = 0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    @(posedge clk); #1;
    if (which == 0) begin if0.rx_valid = 1'b1; if0.rx_data = b; end
    else begin if1.rx_valid = 1'b1; if1.rx_data = b; end
    @(posedge clk); #1;
    if0.rx_valid = 1'b0;
    if1.rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input int which, input logic [7:0] m, input logic [7:0] k, input logic [7:0] n);
    send_byte(which, 8'hA5);
    send_byte(which, m);
    send_byte(which, k);
    send_byte(which, n);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin @(posedge clk); i++; end
    repeat (30) @(posedge clk);
    #1;
    check(tag, tx_q.size(), n);
  endtask

  task automatic check_tx(input string tag, input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i),
            (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(bytes[8*i +: 8]));
  endtask

  task automatic check_wr(input string tag, input int which_b, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (which_b == 0) begin
        check($sformatf("%s_addr[%0d]", tag, i), (i < wa_addr.size()) ? 32'(wa_addr[i]) : 32'hFFFF_FFFF, i);
        check($sformatf("%s_data[%0d]", tag, i), (i < wa_data.size()) ? 32'(wa_data[i]) : 32'hFFFF_FFFF, base + i);
      end else begin
        check($sformatf("%s_addr[%0d]", tag, i), (i < wb_addr.size()) ? 32'(wb_addr[i]) : 32'hFFFF_FFFF, i);
        check($sformatf("%s_data[%0d]", tag, i), (i < wb_data.size()) ? 32'(wb_data[i]) : 32'hFFFF_FFFF, base + i);
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    if0.rx_valid = 1'b0; if0.rx_data = '0;
    if1.rx_valid = 1'b0; if1.rx_data = '0;
    for (int i = 0; i < 64; i++) res_mem[i] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",      32'(if0.state), 0);
    check("rst_tx_start",   32'(if0.tx_start), 0);
    check("rst_tx_data",    32'(if0.tx_data), 0);
    check("rst_mult_start", 32'(if0.mult_start), 0);
    check("rst_dims",       32'({if0.dim_m, if0.dim_k, if0.dim_n}), 0);
    check("rst_wr_en",      32'({if0.wr_en_a, if0.wr_en_b}), 0);
    check("rst_wr_addr",    32'(if0.wr_addr), 0);
    check("rst_wr_data",    32'(if0.wr_data), 0);
    check("rst_res_addr",   32'(if0.res_rd_addr), 0);
    check("rst_err",        32'(if0.err_code), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (if0.state != 3'd0 || if0.tx_start || if0.mult_start || if0.wr_en_a || if0.wr_en_b) bad++;
    end
    check("idle_100_cycles", bad, 0);

    // 2x3 by 3x2, four results streamed with a slow tx
    res_mem[0] = 16'h1101; res_mem[1] = 16'h2202; res_mem[2] = 16'h3303; res_mem[3] = 16'h4404;
    clear_logs();
    send_hdr(0, 8'd2, 8'd3, 8'd2);
    for (int i = 1; i <= 6; i++)  send_byte(0, 8'(i));
    for (int i = 7; i <= 12; i++) send_byte(0, 8'(i));
    wait_tx("t232_tx_count", 8, 3000);
    check("t232_dims", 32'({if0.dim_m, if0.dim_k, if0.dim_n}), 32'({4'd2, 4'd3, 4'd2}));
    check("t232_wa_count", wa_data.size(), 6);
    check_wr("t232_a", 0, 6, 1);
    check("t232_wb_count", wb_data.size(), 6);
    check_wr("t232_b", 1, 6, 7);
    check("t232_mult_start_count", ms_cnt, 1);
    check("t232_mult_start_latency", ms_gap, 1);
    check_tx("t232_tx", 8, 64'h4404_3303_2202_1101);
    check("t232_tx_while_busy", busy_viol, 0);
    check("t232_tx_gap", gap_viol, 0);
    check("t232_err", 32'(if0.err_code), 0);
    check("t232_state", 32'(if0.state), 0);

    // 1x1x1, first tx_start three cycles after mult_done
    res_mem[0] = 16'h0102;
    clear_logs();
    send_hdr(0, 8'd1, 8'd1, 8'd1);
    send_byte(0, 8'd5);
    send_byte(0, 8'd6);
    wait_tx("t111_tx_count", 2, 500);
    check_tx("t111_tx", 2, 64'h0102);
    check("t111_done_to_tx", first_tx_cyc - done_cyc, 3);

    // 1x2 by 2x2, two results, tx busy 5 cycles per byte
    res_mem[0] = 16'h0102; res_mem[1] = 16'h0304;
    clear_logs();
    send_hdr(0, 8'd1, 8'd2, 8'd2);
    for (int i = 0; i < 6; i++) send_byte(0, 8'(8'h20 + i));
    wait_tx("t122_tx_count", 4, 1000);
    check_tx("t122_tx", 4, 64'h0304_0102);
    check("t122_wa_count", wa_data.size(), 2);
    check("t122_wb_count", wb_data.size(), 4);
    check("t122_tx_while_busy", busy_viol, 0);
    check("t122_tx_gap", gap_viol, 0);

    // Bad dimensions: zero, then above MAX_DIM
    clear_logs();
    send_hdr(0, 8'd0, 8'd2, 8'd2);
    wait_tx("dim0_tx_count", 1, 200);
    check("dim0_err", 32'(if0.err_code), 1);
    check_tx("dim0_tx", 1, 64'hEE);
    check("dim0_writes", wa_data.size() + wb_data.size(), 0);
    check("dim0_state", 32'(if0.state), 0);
    clear_logs();
    send_hdr(0, 8'd9, 8'd1, 8'd1);
    wait_tx("dim9_tx_count", 1, 200);
    check("dim9_err", 32'(if0.err_code), 1);
    check_tx("dim9_tx", 1, 64'hEE);
    check("dim9_writes", wa_data.size() + wb_data.size(), 0);
    check("dim9_state", 32'(if0.state), 0);

    // Receive timeout after 3 of 4 A elements
    clear_logs();
    send_hdr(0, 8'd2, 8'd2, 8'd2);
    send_byte(0, 8'h11);
    send_byte(0, 8'h12);
    send_byte(0, 8'h13);
    wait_tx("to_tx_count", 1, TO + 100);
    check("to_err", 32'(if0.err_code), 2);
    check_tx("to_tx", 1, 64'hEE);
    check("to_wa_count", wa_data.size(), 3);
    check("to_state", 32'(if0.state), 0);

    // Recovery with a clean transfer
    res_mem[0] = 16'hBEEF;
    clear_logs();
    send_hdr(0, 8'd1, 8'd1, 8'd1);
    send_byte(0, 8'd3);
    send_byte(0, 8'd4);
    wait_tx("rec_tx_count", 2, 500);
    check("rec_err", 32'(if0.err_code), 0);
    check_tx("rec_tx", 2, 64'hBEEF);
    check_wr("rec_a", 0, 1, 3);
    check_wr("rec_b", 1, 1, 4);

    // Two-byte elements on the second instance
    send_hdr(1, 8'd1, 8'd1, 8'd1);
    send_byte(1, 8'h34);
    send_byte(1, 8'h12);
    send_byte(1, 8'h78);
    send_byte(1, 8'h56);
    repeat (5) @(posedge clk);
    #1;
    check("e2_wa_count", w1a_data.size(), 1);
    check("e2_wa_data", (w1a_data.size() > 0) ? 32'(w1a_data[0]) : 32'hFFFF_FFFF, 32'h1234);
    check("e2_wb_data", (w1b_data.size() > 0) ? 32'(w1b_data[0]) : 32'hFFFF_FFFF, 32'h5678);
    check("e2_mult_start", ms1_cnt, 1);
    check("e2_state", 32'(if1.state), 4);

    // Reset mid-header discards progress, no pulse after release
    send_byte(0, 8'hA5);
    send_byte(0, 8'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrst_state", 32'(if0.state), 0);
    check("midrst_dim_m", 32'(if0.dim_m), 0);
    clear_logs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_tx", tx_q.size(), 0);
    check("midrst_no_mult", ms_cnt, 0);
    check("midrst_idle", 32'(if0.state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
